// File: rtl/main_mem_arbiter.sv
// Round-robin arbiter that serialises cache-level read requests onto the single-ported main memory.
// Optional MEM_ARB_PERF_EN adds the perf_grants / perf_busy counters.
module main_mem_arbiter #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned ADDR_W  = 11,
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned MEM_LAT = 1
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
  output logic [NUM_REQ-1:0]        req_ready,
  output logic [NUM_REQ-1:0]        resp_valid,
  output logic [DATA_W-1:0]         resp_data,
  output logic                      mem_rd,
  output logic [ADDR_W-1:0]         mem_addr,
  input  logic [DATA_W-1:0]         mem_data,
  output logic                      busy
`ifdef MEM_ARB_PERF_EN
  ,
  output logic [NUM_REQ*16-1:0]     perf_grants,
  output logic [31:0]               perf_busy
`endif
);

  localparam int unsigned PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int unsigned CNT_W = $clog2(MEM_LAT + 1);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  state_t             state;
  logic [PTR_W-1:0]   rr_ptr;
  logic [PTR_W-1:0]   win;
  logic [PTR_W-1:0]   idx;
  logic               found;
  logic [NUM_REQ-1:0] owner;
  logic [CNT_W-1:0]   wait_cnt;
  logic [ADDR_W-1:0]  addr_arr [NUM_REQ];

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
    assign addr_arr[g] = req_addr[g*ADDR_W +: ADDR_W];
  end

  // First requesting index scanning upward from rr_ptr+1, wrapping
  always_comb begin
    found = 1'b0;
    win   = rr_ptr;
    idx   = '0;
    for (int unsigned k = 1; k <= NUM_REQ; k++) begin
      idx = PTR_W'((32'(rr_ptr) + k) % NUM_REQ);
      if (!found && req_valid[idx]) begin
        found = 1'b1;
        win   = idx;
      end
    end
  end

  // Sequencer: outputs are registered alongside the state they belong to
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      rr_ptr     <= PTR_W'(NUM_REQ - 1);
      owner      <= '0;
      wait_cnt   <= '0;
      req_ready  <= '0;
      resp_valid <= '0;
      resp_data  <= '0;
      mem_rd     <= 1'b0;
      mem_addr   <= '0;
      busy       <= 1'b0;
    end else begin
      req_ready  <= '0;
      resp_valid <= '0;
      mem_rd     <= 1'b0;
      case (state)
        IDLE: begin
          if (found) begin
            req_ready <= NUM_REQ'(1) << win;
            owner     <= NUM_REQ'(1) << win;
            rr_ptr    <= win;
            mem_rd    <= 1'b1;
            mem_addr  <= addr_arr[win];
            busy      <= 1'b1;
            state     <= ISSUE;
          end
        end
        ISSUE: begin
          wait_cnt <= CNT_W'(MEM_LAT);
          state    <= WAIT;
        end
        WAIT: begin
          wait_cnt <= wait_cnt - CNT_W'(1);
          if (wait_cnt == CNT_W'(1)) begin
            resp_data  <= mem_data;
            resp_valid <= owner;
            state      <= RESP;
          end
        end
        RESP: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef MEM_ARB_PERF_EN
  // Saturating per-requester grant counters
  for (genvar g = 0; g < NUM_REQ; g++) begin : g_perf
    logic [15:0] grant_cnt;
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        grant_cnt <= '0;
      end else if (req_ready[g] && (grant_cnt != 16'hFFFF)) begin
        grant_cnt <= grant_cnt + 16'd1;
      end
    end
    assign perf_grants[g*16 +: 16] = grant_cnt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_busy <= '0;
    end else if (busy) begin
      perf_busy <= perf_busy + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_main_mem_arbiter.sv
// Scoreboard bench for main_mem_arbiter: directed requests, monitor checks grants and responses.
module tb_main_mem_arbiter;

  localparam int unsigned NUM_REQ = 4;
  localparam int unsigned ADDR_W  = 11;
  localparam int unsigned DATA_W  = 32;
  localparam int unsigned MEM_LAT = 1;

  logic                      clk;
  logic                      rst_n;
  logic [NUM_REQ-1:0]        req_valid;
  logic [NUM_REQ*ADDR_W-1:0] req_addr;
  logic [NUM_REQ-1:0]        req_ready;
  logic [NUM_REQ-1:0]        resp_valid;
  logic [DATA_W-1:0]         resp_data;
  logic                      mem_rd;
  logic [ADDR_W-1:0]         mem_addr;
  logic [DATA_W-1:0]         mem_data;
  logic                      busy;
`ifdef MEM_ARB_PERF_EN
  logic [NUM_REQ*16-1:0]     perf_grants;
  logic [31:0]               perf_busy;
`endif

  main_mem_arbiter #(
    .NUM_REQ(NUM_REQ), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .MEM_LAT(MEM_LAT)
  ) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_addr(req_addr),
    .req_ready(req_ready), .resp_valid(resp_valid), .resp_data(resp_data),
    .mem_rd(mem_rd), .mem_addr(mem_addr), .mem_data(mem_data), .busy(busy)
`ifdef MEM_ARB_PERF_EN
    , .perf_grants(perf_grants), .perf_busy(perf_busy)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory model with mem[i] = i; data is only meaningful MEM_LAT cycles after the sampling edge
  logic [DATA_W-1:0] pipe [MEM_LAT];
  always @(posedge clk) begin
    pipe[0] <= mem_rd ? DATA_W'(mem_addr) : 32'hDEADBEEF;
    for (int i = 1; i < int'(MEM_LAT); i++) pipe[i] <= pipe[i-1];
  end
  assign mem_data = pipe[MEM_LAT-1];

  typedef struct {
    int          idx;
    logic [31:0] val;
  } exp_t;

  exp_t grant_q[$];
  exp_t resp_q[$];
  int   n_cmp = 0;
  int   n_err = 0;
  int   cyc   = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Monitor: pops expectations whenever the DUT grants or responds
  bit   pending = 1'b0;
  bit   prev_rd = 1'b0;
  int   resp_cyc = 0;
  exp_t g, r;
  always @(negedge clk) begin
    if (!rst_n) begin
      pending = 1'b0;
      prev_rd = 1'b0;
    end else begin
      if (mem_rd) chk("mem_rd_back_to_back", 64'(prev_rd), 64'd0);
      if (req_ready != '0 || mem_rd) begin
        if (grant_q.size() == 0) begin
          chk("unexpected_grant", {req_ready, mem_rd}, 64'd0);
        end else begin
          g = grant_q.pop_front();
          chk("grant_ready", req_ready, 64'(NUM_REQ'(1) << g.idx));
          chk("grant_mem_rd", 64'(mem_rd), 64'd1);
          chk("grant_mem_addr", mem_addr, g.val);
          pending  = 1'b1;
          resp_cyc = cyc + 1 + int'(MEM_LAT);
        end
      end
      if (resp_valid != '0) begin
        if (resp_q.size() == 0) begin
          chk("unexpected_resp", resp_valid, 64'd0);
        end else begin
          r = resp_q.pop_front();
          chk("resp_valid", resp_valid, 64'(NUM_REQ'(1) << r.idx));
          chk("resp_data", resp_data, r.val);
          chk("resp_latency", 64'(cyc), 64'(resp_cyc));
        end
        pending = 1'b0;
      end else if (pending && cyc >= resp_cyc && resp_q.size() != 0) begin
        r = resp_q.pop_front();
        chk("resp_missing", resp_valid, 64'(NUM_REQ'(1) << r.idx));
        pending = 1'b0;
      end
      prev_rd = mem_rd;
    end
  end

  task automatic set_addr(input int i, input logic [ADDR_W-1:0] a);
    req_addr[i*ADDR_W +: ADDR_W] = a;
  endtask

  task automatic expect_access(input int i, input logic [ADDR_W-1:0] a, input logic [31:0] d,
                               input bit with_resp);
    grant_q.push_back('{i, 32'(a)});
    if (with_resp) resp_q.push_back('{i, d});
  endtask

  task automatic wait_ready(input int i);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!req_ready[i] && n < 50);
    if (!req_ready[i]) chk("ready_timeout", req_ready, 64'(NUM_REQ'(1) << i));
    req_valid[i] = 1'b0;
  endtask

  task automatic issue(input int i, input logic [ADDR_W-1:0] a, input logic [31:0] d);
    set_addr(i, a);
    expect_access(i, a, d, 1'b1);
    req_valid[i] = 1'b1;
    wait_ready(i);
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((grant_q.size() != 0 || resp_q.size() != 0 || busy) && n < 300) begin
      @(negedge clk);
      n++;
    end
    @(negedge clk);
    if (n >= 300) chk("idle_timeout", 64'(busy), 64'd0);
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_req_ready"}, req_ready, 64'd0);
    chk({tag, "_resp_valid"}, resp_valid, 64'd0);
    chk({tag, "_mem_rd"}, 64'(mem_rd), 64'd0);
    chk({tag, "_busy"}, 64'(busy), 64'd0);
    chk({tag, "_mem_addr"}, mem_addr, 64'd0);
    chk({tag, "_resp_data"}, resp_data, 64'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n     = 1'b0;
    req_valid = '0;
    req_addr  = '0;
    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    rst_n = 1'b1;
    @(negedge clk);

    // All four at once: reset pointer gives order 0,1,2,3
    set_addr(0, 11'h010); set_addr(1, 11'h020); set_addr(2, 11'h030); set_addr(3, 11'h040);
    expect_access(0, 11'h010, 32'h0000_0010, 1'b1);
    expect_access(1, 11'h020, 32'h0000_0020, 1'b1);
    expect_access(2, 11'h030, 32'h0000_0030, 1'b1);
    expect_access(3, 11'h040, 32'h0000_0040, 1'b1);
    req_valid = 4'hF;
    for (int n = 0; n < 100 && req_valid != '0; n++) begin
      @(negedge clk);
      req_valid = req_valid & ~req_ready;
    end
    chk("all_four_drained", req_valid, 64'd0);
    req_valid = '0;
    wait_idle();

    // Single request with busy tracking
    issue(0, 11'h005, 32'h0000_0005);
    chk("busy_during_access", 64'(busy), 64'd1);
    wait_idle();
    chk("busy_after_access", 64'(busy), 64'd0);

    // Fairness: 1 and 3 held for 8 grants must alternate 1,3,1,3,...
    set_addr(1, 11'h111); set_addr(3, 11'h333);
    for (int k = 0; k < 4; k++) begin
      expect_access(1, 11'h111, 32'h0000_0111, 1'b1);
      expect_access(3, 11'h333, 32'h0000_0333, 1'b1);
    end
    req_valid = 4'b1010;
    begin
      int grants = 0;
      for (int n = 0; n < 200 && grants < 8; n++) begin
        @(negedge clk);
        if (req_ready != '0) grants++;
      end
      chk("fairness_grants", 64'(grants), 64'd8);
    end
    req_valid = '0;
    wait_idle();

    // Address boundaries
    issue(2, 11'h7FF, 32'h0000_07FF);
    wait_idle();
    issue(2, 11'h000, 32'h0000_0000);
    wait_idle();

    // Reset during WAIT drops the access; no response may follow
    expect_access(0, 11'h0AA, 32'h0000_00AA, 1'b0);
    set_addr(0, 11'h0AA);
    req_valid[0] = 1'b1;
    wait_ready(0);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1 check_reset_outputs("mid_wait_reset");
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    issue(1, 11'h123, 32'h0000_0123);
    wait_idle();

`ifdef MEM_ARB_PERF_EN
    rst_n = 1'b0;
    @(negedge clk);
    chk("perf_clear_grants", perf_grants, 64'd0);
    chk("perf_clear_busy", perf_busy, 64'd0);
    rst_n = 1'b1;
    @(negedge clk);
    for (int k = 0; k < 5; k++) issue(0, 11'(11'h040 + k), 32'(32'h40 + k));
    wait_idle();
    chk("perf_grants0", perf_grants[15:0], 64'd5);
    chk("perf_grants_others", perf_grants[NUM_REQ*16-1:16], 64'd0);
    chk("perf_busy", perf_busy, 64'(5 * (2 + MEM_LAT)));
`endif

    repeat (5) @(negedge clk);
    chk("grant_q_empty", 64'(grant_q.size()), 64'd0);
    chk("resp_q_empty", 64'(resp_q.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
